// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 port arbiter: LC-3b word/line types, FSM states,
// requester sides and the conflict-resolution helper.
package l2_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} l2_arb_state_t;
  typedef enum logic       {ARB_I = 1'b0, ARB_D = 1'b1} l2_arb_side_t;

  localparam int STAT_W = 16;

  // With alternation enabled the side that did not win last time takes the
  // conflict; otherwise the D-side always wins.
  function automatic l2_arb_side_t conflict_winner(input bit round_robin,
                                                   input l2_arb_side_t last_grant);
    return (round_robin && last_grant == ARB_D) ? ARB_I : ARB_D;
  endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Cache line port: master issues address/data/strobes, slave returns line and
// a one-cycle completion pulse.
interface l2_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              read;
  logic              write;
  logic              resp;

  modport master (output address, wdata, read, write, input  rdata, resp);
  modport slave  (input  address, wdata, read, write, output rdata, resp);
endinterface

// File: rtl/l2_arbiter_stats.sv
// Grant and conflict counters, wrapping at 16'hFFFF; only instantiated when
// L2_ARB_STATS_EN is defined.
module l2_arb_stats
  import l2_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              inc_d,
  input  logic              inc_conflict,
  output logic [STAT_W-1:0] stat_i_grants,
  output logic [STAT_W-1:0] stat_d_grants,
  output logic [STAT_W-1:0] stat_conflicts
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (inc_i)        stat_i_grants  <= stat_i_grants  + STAT_W'(1);
      if (inc_d)        stat_d_grants  <= stat_d_grants  + STAT_W'(1);
      if (inc_conflict) stat_conflicts <= stat_conflicts + STAT_W'(1);
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates the split I/D L1 caches onto the single L2 port, one line
// transaction at a time. Define L2_ARB_STATS_EN to get grant/conflict counters.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = 128,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  l2_arbiter_if.slave       icache,
  l2_arbiter_if.slave       dcache,
  l2_arbiter_if.master      l2,
  output logic              busy,
  output logic              grant_d,
  output logic [STAT_W-1:0] stat_i_grants,
  output logic [STAT_W-1:0] stat_d_grants,
  output logic [STAT_W-1:0] stat_conflicts
);

  l2_arb_state_t state, state_next;
  l2_arb_side_t  last_grant;
  logic          req_i, req_d;
  logic          grant_i_evt, grant_d_evt;

  assign req_i = icache.read | icache.write;
  assign req_d = dcache.read | dcache.write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_i && req_d)
          state_next = (conflict_winner(ROUND_ROBIN != 0, last_grant) == ARB_D) ? SERVE_D : SERVE_I;
        else if (req_d)
          state_next = SERVE_D;
        else if (req_i)
          state_next = SERVE_I;
      end
      SERVE_I, SERVE_D: if (l2.resp) state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  assign grant_i_evt = (state == IDLE) && (state_next == SERVE_I);
  assign grant_d_evt = (state == IDLE) && (state_next == SERVE_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           last_grant <= ARB_I;
    else if (grant_d_evt) last_grant <= ARB_D;
    else if (grant_i_evt) last_grant <= ARB_I;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    l2.address  = {ADDR_W{1'b0}};
    l2.wdata    = {LINE_W{1'b0}};
    l2.read     = 1'b0;
    l2.write    = 1'b0;
    icache.resp = 1'b0;
    dcache.resp = 1'b0;
    busy        = 1'b0;
    grant_d     = 1'b0;
    case (state)
      SERVE_I: begin
        l2.address  = icache.address;
        l2.wdata    = icache.wdata;
        l2.read     = icache.read;
        l2.write    = icache.write;
        icache.resp = l2.resp;
        busy        = 1'b1;
      end
      SERVE_D: begin
        l2.address  = dcache.address;
        l2.wdata    = dcache.wdata;
        l2.read     = dcache.read;
        l2.write    = dcache.write;
        dcache.resp = l2.resp;
        busy        = 1'b1;
        grant_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the granted side's resp qualifies it.
  assign icache.rdata = l2.rdata;
  assign dcache.rdata = l2.rdata;

`ifdef L2_ARB_STATS_EN
  l2_arb_stats u_stats (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc_i          (grant_i_evt),
    .inc_d          (grant_d_evt),
    .inc_conflict   ((state == IDLE) && req_i && req_d),
    .stat_i_grants  (stat_i_grants),
    .stat_d_grants  (stat_d_grants),
    .stat_conflicts (stat_conflicts)
  );
`else
  assign stat_i_grants  = '0;
  assign stat_d_grants  = '0;
  assign stat_conflicts = '0;
`endif

`ifndef SYNTHESIS
  a_hold_i: assert property (@(posedge clk) disable iff (!rst_n) (state == SERVE_I) |-> req_i);
  a_hold_d: assert property (@(posedge clk) disable iff (!rst_n) (state == SERVE_D) |-> req_d);
  a_rw_i:   assert property (@(posedge clk) disable iff (!rst_n) !(icache.read && icache.write));
  a_rw_d:   assert property (@(posedge clk) disable iff (!rst_n) !(dcache.read && dcache.write));
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: a round-robin and a fixed-priority instance share the
// same requester stimulus and are checked every cycle against a transaction model.
module tb_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
`ifdef L2_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic          busy;
    logic          grant_d;
    logic          i_resp;
    logic          d_resp;
    logic          l2_rd;
    logic          l2_wr;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] i_rdata;
    logic [LW-1:0] d_rdata;
    logic [15:0]   s_i;
    logic [15:0]   s_d;
    logic [15:0]   s_c;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] i_wdata = '0, d_wdata = '0, l2_line = '0;
  logic          i_rd = 1'b0, i_wr = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic          force_resp = 1'b0;
  int            lat = 3;

  int compared = 0;
  int mismatched = 0;

  obs_t obs  [2];
  obs_t expv [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) ic ();
    l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) dc ();
    l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) l2 ();
    logic        busy, grant_d;
    logic [15:0] s_i, s_d, s_c;
    int          cnt = 0;
    int          owner = 0;   // 0: nobody, 1: I-side, 2: D-side
    bit          last_d = 1'b0;
    int          n_i = 0, n_d = 0, n_c = 0;
    logic        exp_resp;
    obs_t        e;

    assign ic.address = i_addr;
    assign ic.wdata   = i_wdata;
    assign ic.read    = i_rd;
    assign ic.write   = i_wr;
    assign dc.address = d_addr;
    assign dc.wdata   = d_wdata;
    assign dc.read    = d_rd;
    assign dc.write   = d_wr;
    assign l2.rdata   = l2_line;
    assign l2.resp    = force_resp | ((l2.read | l2.write) && cnt == lat);

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .ROUND_ROBIN(k == 0 ? 1 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .icache(ic), .dcache(dc), .l2(l2),
      .busy(busy), .grant_d(grant_d),
      .stat_i_grants(s_i), .stat_d_grants(s_d), .stat_conflicts(s_c)
    );

    // L2 stand-in: responds once the strobe has been up for lat cycles.
    always @(posedge clk) cnt <= (l2.read | l2.write) ? cnt + 1 : 0;

    assign exp_resp = force_resp | (owner != 0 && cnt == lat);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        owner <= 0; last_d <= 1'b0; n_i <= 0; n_d <= 0; n_c <= 0;
      end else if (owner == 0) begin : pick
        int  win;
        bit  want_i, want_d;
        want_i = i_rd | i_wr;
        want_d = d_rd | d_wr;
        win = 0;
        if (want_d && (!want_i || k == 1 || !last_d)) win = 2;
        else if (want_i)                               win = 1;
        if (want_i && want_d) n_c <= (n_c + 1) % 65536;
        if (win == 1) begin owner <= 1; last_d <= 1'b0; n_i <= (n_i + 1) % 65536; end
        if (win == 2) begin owner <= 2; last_d <= 1'b1; n_d <= (n_d + 1) % 65536; end
      end else if (exp_resp) begin
        owner <= 0;
      end
    end

    always_comb begin
      e = '0;
      e.i_rdata = l2_line;
      e.d_rdata = l2_line;
      if (owner == 1) begin
        e.busy = 1'b1; e.l2_rd = i_rd; e.l2_wr = i_wr;
        e.l2_addr = i_addr; e.l2_wdata = i_wdata; e.i_resp = exp_resp;
      end
      if (owner == 2) begin
        e.busy = 1'b1; e.grant_d = 1'b1; e.l2_rd = d_rd; e.l2_wr = d_wr;
        e.l2_addr = d_addr; e.l2_wdata = d_wdata; e.d_resp = exp_resp;
      end
      if (STATS) begin
        e.s_i = n_i[15:0]; e.s_d = n_d[15:0]; e.s_c = n_c[15:0];
      end
    end

    assign obs[k]  = {busy, grant_d, ic.resp, dc.resp, l2.read, l2.write, l2.address,
                      l2.wdata, ic.rdata, dc.rdata, s_i, s_d, s_c};
    assign expv[k] = e;
  end

  int   n_resp [2]  = '{0, 0};
  int   n_iresp [2] = '{0, 0};
  int   n_dresp [2] = '{0, 0};
  int   gcnt [2]    = '{0, 0};
  bit   gseq [2][64];
  logic prev_busy [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL cycle_compare dut%0d t=%0t got %h required %h", k, $time, obs[k], expv[k]);
      end
      if (obs[k].i_resp) n_iresp[k]++;
      if (obs[k].d_resp) n_dresp[k]++;
      if (obs[k].i_resp | obs[k].d_resp) n_resp[k]++;
      if (obs[k].busy && !prev_busy[k]) begin
        if (gcnt[k] < 64) gseq[k][gcnt[k]] = obs[k].grant_d;
        gcnt[k]++;
      end
      prev_busy[k] = obs[k].busy;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic wait_resps(input int target, input string name);
    int budget = 200;
    while (n_resp[0] < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    compared++;
    if (n_resp[0] < target) begin
      mismatched++;
      $display("FAIL %s: timeout with %0d responses, required %0d", name, n_resp[0], target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, b1, r0, i1, d0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", obs[0].busy, 1'b0);
    check("reset_grant_d", obs[0].grant_d, 1'b0);
    check("reset_strobes", {obs[0].l2_rd, obs[0].l2_wr}, 2'b00);

    // Single I read, 3-cycle L2 latency
    l2_line = {16{8'hA5}};
    @(posedge clk); #1 i_addr = 16'h1230; i_rd = 1'b1;
    #1 check("t1_no_strobe_cycle_n", obs[0].l2_rd, 1'b0);
    @(posedge clk); #1;
    check("t1_strobe_n1", {obs[0].l2_rd, obs[0].l2_addr}, {1'b1, 16'h1230});
    repeat (3) @(posedge clk);
    #1;
    check("t1_resp_cycle", obs[0].i_resp, 1'b1);
    check("t1_rdata", obs[0].i_rdata, {16{8'hA5}});
    @(posedge clk); #1 i_rd = 1'b0;
    repeat (2) @(posedge clk);
    check("t1_iresp_count", n_iresp[0], 1);
    check("t1_dresp_count", n_dresp[0], 0);
    check("t1_stat_i", obs[0].s_i, STATS ? 16'd1 : 16'd0);
    check("t1_model_n_i", g_dut[0].n_i, 1);

    // Simultaneous I read and D write: D first, then I
    @(posedge clk); #1;
    i_addr = 16'h0040; i_rd = 1'b1;
    d_addr = 16'h8000; d_wdata = 128'h1; d_wr = 1'b1;
    @(posedge clk); #1;
    check("t2_first_grant_d", {obs[0].grant_d, obs[0].l2_wr, obs[0].l2_addr}, {2'b11, 16'h8000});
    check("t2_first_wdata", obs[0].l2_wdata, 128'h1);
    wait_resps(2, "t2_d_resp");
    #1 d_wr = 1'b0;
    @(posedge clk); #1;
    check("t2_second_grant_i", {obs[0].busy, obs[0].grant_d, obs[0].l2_rd, obs[0].l2_addr},
          {3'b101, 16'h0040});
    wait_resps(3, "t2_i_resp");
    #1 i_rd = 1'b0;
    @(posedge clk); #1;
    check("t2_stat_conflicts", obs[0].s_c, STATS ? 16'd1 : 16'd0);
    check("t2_model_n_c", g_dut[0].n_c, 1);
    check("t2_fp_dresp", n_dresp[1], 1);

    // Both sides requesting continuously for 6 transactions
    b0 = gcnt[0]; b1 = gcnt[1]; i1 = n_iresp[1]; r0 = n_resp[0];
    @(posedge clk); #1;
    i_addr = 16'h0100; i_rd = 1'b1;
    d_addr = 16'h0200; d_rd = 1'b1;
    wait_resps(r0 + 6, "t3_six_resps");
    #1 i_rd = 1'b0; d_rd = 1'b0;
    repeat (2) @(posedge clk);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("t3_rr_grant%0d", j), gseq[0][b0 + j], (j % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("t3_fp_grant%0d", j), gseq[1][b1 + j], 1'b1);
    end
    check("t3_fp_i_starved", n_iresp[1] - i1, 0);
    check("t3_stat_conflicts", obs[0].s_c, STATS ? 16'd7 : 16'd0);
    check("t3_model_n_c", g_dut[0].n_c, 7);

    // D back-to-back with I idle: no forced alternation
    b0 = gcnt[0]; r0 = n_resp[0];
    @(posedge clk); #1 d_addr = 16'h0300; d_rd = 1'b1;
    wait_resps(r0 + 2, "t6_two_resps");
    #1 d_rd = 1'b0;
    repeat (2) @(posedge clk);
    check("t6_grant0_d", gseq[0][b0], 1'b1);
    check("t6_grant1_d", gseq[0][b0 + 1], 1'b1);

    // Reset during SERVE_D one cycle before l2_resp
    d0 = n_dresp[0];
    @(posedge clk); #1 d_addr = 16'h3000; d_rd = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("t4_busy_before_reset", {obs[0].busy, obs[0].grant_d}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("t4_async_drop", {obs[0].busy, obs[0].grant_d, obs[0].l2_rd, obs[0].l2_wr, obs[0].d_resp},
          5'b00000);
    d_rd = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_no_dresp", n_dresp[0] - d0, 0);
    check("t4_stats_zero", {obs[0].s_i, obs[0].s_d, obs[0].s_c}, 48'h0);
    check("t4_idle_after", obs[0].busy, 1'b0);

    // Spurious l2_resp in IDLE
    @(posedge clk); #1 force_resp = 1'b1;
    #1 check("t5_spurious_resp", {obs[0].i_resp, obs[0].d_resp, obs[1].i_resp, obs[1].d_resp}, 4'b0000);
    @(posedge clk); #1 force_resp = 1'b0;
    check("t5_still_idle", {obs[0].busy, obs[1].busy}, 2'b00);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single unified L2 cache port between the split L1 caches: instruction cache (I) and data cache (D).
- Sits between the two L1 miss/writeback ports and the L2 upstream port (mem_address/mem_wdata/mem_read/mem_write/mem_rdata/mem_resp).
- Serves one line transaction at a time and holds the grant until L2 responds.
- Returns the L2 response only to the granted requester.

Parameters:
- ADDR_W, 16, address width (lc3b_word)
- LINE_W, 128, cache line width (lc3b_cache_line)
- ROUND_ROBIN, 1, 1 = alternate on conflict; 0 = fixed priority, D always wins

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- icache_address  in  ADDR_W  I-side line address
- icache_wdata  in  LINE_W  I-side write line (unused by I-cache today; routed anyway)
- icache_read  in  1  I-side read request
- icache_write  in  1  I-side write request
- icache_rdata  out  LINE_W  L2 read data to I-side
- icache_resp  out  1  I-side completion pulse
- dcache_address, dcache_wdata, dcache_read, dcache_write, dcache_rdata, dcache_resp: same widths and meanings, D-side
- l2_address  out  ADDR_W  to L2 mem_address
- l2_wdata  out  LINE_W  to L2 mem_wdata
- l2_read  out  1  to L2 mem_read
- l2_write  out  1  to L2 mem_write
- l2_rdata  in  LINE_W  from L2 mem_rdata
- l2_resp  in  1  from L2 mem_resp
- busy  out  1  high while a transaction is granted
- grant_d  out  1  1 = D-side owns L2, 0 = I-side (valid when busy)
- stat_i_grants  out  16  I-side grants count (optional feature)
- stat_d_grants  out  16  D-side grants count (optional feature)
- stat_conflicts  out  16  cycles with both sides requesting in IDLE (optional feature)

Behaviour:
- Request definition: req_x = x_read | x_write. Requesters hold address, data and strobes stable until x_resp (MP3 L1 convention).
- FSM states: IDLE, SERVE_I, SERVE_D. Register state on clk, reset to IDLE.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only one side requests: go to that side's SERVE state.
  - Both request, ROUND_ROBIN=1: grant the side not in last_grant.
  - Both request, ROUND_ROBIN=0: grant D.
  - last_grant updates on every grant; reset value = I, so D wins the first conflict.
- SERVE_x:
  - l2_address/l2_wdata/l2_read/l2_write mirror requester x combinationally.
  - Stay in SERVE_x until l2_resp=1.
  - On the l2_resp cycle: x_resp=1 and x_rdata=l2_rdata (same cycle, combinational). Next state is IDLE.
- Latency: request sampled in IDLE at cycle N; L2 strobes assert at N+1; response forwarded in the same cycle as l2_resp.
  - The mandatory IDLE cycle after each response lets the L1 deassert its strobes.
  - Minimum overhead: 2 cycles per transaction.
- Output values:
  - In IDLE: l2_read=l2_write=0, l2_address/l2_wdata=0, both x_resp=0, busy=0.
  - Ungranted side: x_resp always 0.
  - x_rdata: driven with l2_rdata unconditionally (only qualified by x_resp).
- Reset values: state=IDLE, last_grant=I, busy=0, grant_d=0, all resp/strobes 0, stat counters 0. Async assertion at any point, including mid-SERVE, returns to IDLE immediately; the in-flight transaction is dropped (L2 is reset on the same rst_n).
- Boundary conditions:
  - l2_resp in IDLE: ignored, no x_resp.
  - Granted requester drops its request mid-SERVE: protocol violation; the arbiter keeps the grant until l2_resp (simulation assertion flags it).
  - x_read & x_write both high: violation; both strobes are forwarded and a simulation assertion fires.
  - Ungranted side requesting during SERVE: waits, sees no resp; conflict is evaluated at the next IDLE.
  - Back-to-back requests from the same side with the other side idle: serviced every 2+L2 cycles; no forced alternation.

Optional Feature:
- Macro: L2_ARB_STATS_EN.
- Defined: three 16-bit counters, wrapping at 16'hFFFF→0, read by the perf-counter logic alongside l2_miss/l2_total.
  - stat_i_grants increments on each IDLE→SERVE_I transition.
  - stat_d_grants increments on each IDLE→SERVE_D transition.
  - stat_conflicts increments on each IDLE cycle with both req_i and req_d high.
- Undefined: no counter flops; the stat outputs are tied to 16'h0000.

Decomposition:
- lc3b_types additions:
  - typedef enum l2_arb_state_t {IDLE, SERVE_I, SERVE_D}
  - typedef enum l2_arb_side_t {ARB_I=0, ARB_D=1}
- Reuse the existing lc3b_word and lc3b_cache_line types.
- One natural sub-module: l2_arb_stats, holding the three counters, instantiated only under L2_ARB_STATS_EN. The FSM and muxing stay in l2_arbiter.

Test Plan:
- Single I read, icache_address=16'h1230, L2 responds 3 cycles after l2_read with line 128'hA5.. -> l2_read high from N+1, icache_resp one cycle with rdata 128'hA5.., dcache_resp never high, stat_i_grants=1.
- Simultaneous I read 16'h0040 and D write 16'h8000 data 128'h1 after reset, ROUND_ROBIN=1 -> D is served first with l2_write, then I is served; stat_conflicts=1.
- Both sides requesting continuously for 6 transactions, ROUND_ROBIN=1 -> grants alternate D,I,D,I,D,I. With ROUND_ROBIN=0 -> D is served repeatedly and I waits.
- rst_n pulled low during SERVE_D, 1 cycle before l2_resp -> outputs drop to 0 asynchronously; after release state is IDLE, no dcache_resp, counters are 0.
- Spurious l2_resp in IDLE with no requests -> icache_resp=dcache_resp=0, state remains IDLE.
- Counter wrap with L2_ARB_STATS_EN, stat_d_grants preloaded via 65535 D grants -> the next grant reads 0. Without the macro, all stat outputs read 0 throughout.
